// File: rtl/lut_neuron_table_loader.sv
// ---------------------------------------------------------------------------
// lut_neuron_table_loader
//
// Writer side of a LUT neuron. A truth table of 2**IN_BITS entries, each
// OUT_BITS wide, is streamed in over a valid/ready config port. Once the
// last entry is written the block serves single-cycle-latency lookups,
// where the packed fan-in word is used directly as the table address.
// One instance per neuron, between the config controller and the layer
// datapath.
//
// Parameters
//   IN_BITS    packed fan-in width; table depth is 2**IN_BITS
//   OUT_BITS   activation width per table entry
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous, active-high reset
//   cfg_start  in   pulse: begin (re)loading the table at address 0
//   cfg_valid  in   cfg_data holds a valid entry
//   cfg_ready  out  loader accepts an entry this cycle
//   cfg_data   in   table entry for the current load address
//   cfg_done   out  1-cycle pulse after the last entry is written
//   in_valid   in   lookup request valid
//   in_ready   out  lookup accepted (RUN state only)
//   in_data    in   packed fan-in word = table address
//   out_valid  out  registered lookup result valid
//   out_data   out  table[in_data]
//   cfg_csum   out  (LUT_CSUM_EN only) modulo-2**16 sum of entries
//                   accepted since the last cfg_start
//
// Build option
//   LUT_CSUM_EN  when defined, adds the cfg_csum port and its accumulator.
//                When undefined the port and its logic are absent.
// ---------------------------------------------------------------------------
module lut_neuron_table_loader #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [OUT_BITS-1:0] cfg_data,
    output logic                cfg_done,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data
`ifdef LUT_CSUM_EN
    ,
    output logic [15:0]         cfg_csum
`endif
);

    localparam int                 DEPTH     = 1 << IN_BITS;
    localparam logic [IN_BITS-1:0] LAST_ADDR = '1;
    localparam logic [IN_BITS-1:0] ADDR_ONE  = IN_BITS'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t              state;
    logic [IN_BITS-1:0]  addr;
    logic                wr_en;
    logic                lookup_acc;

    // Table storage: one write port (loader), one asynchronous read port
    // (lookup), mapped to distributed RAM. Contents are never reset.
    logic [OUT_BITS-1:0] table_mem [DEPTH];

    // Result stage registers.
    logic                vld_p1;
    logic [OUT_BITS-1:0] data_p1;
    logic                done_p1;

    // cfg_start takes priority over a coincident entry: the entry is refused
    // so the sender keeps it, and the load restarts at address 0.
    assign cfg_ready  = (state == LOAD) && !cfg_start;
    assign in_ready   = (state == RUN);
    assign wr_en      = cfg_valid && cfg_ready;
    assign lookup_acc = in_valid && in_ready;

    assign cfg_done   = done_p1;
    assign out_valid  = vld_p1;
    assign out_data   = data_p1;

    // ---- stage 0 -> 1: table write --------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_mem[addr] <= cfg_data;
        end
    end

    // ---- stage 0 -> 1: control FSM, load address and lookup result -------
    // A lookup accepted in the same cycle as a cfg_start in RUN still
    // returns its result next cycle; no write can land before that read
    // because writes only happen in LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr    <= '0;
            done_p1 <= 1'b0;
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            done_p1 <= 1'b0;
            vld_p1  <= lookup_acc;
            if (lookup_acc) begin
                data_p1 <= table_mem[in_data];
            end

            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        state <= LOAD;
                        addr  <= '0;
                    end
                end
                LOAD: begin
                    if (cfg_start) begin
                        addr <= '0;
                    end else if (wr_en) begin
                        // Address wraps to 0 on the final entry.
                        addr <= addr + ADDR_ONE;
                        if (addr == LAST_ADDR) begin
                            state   <= RUN;
                            done_p1 <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (cfg_start) begin
                        state <= LOAD;
                        addr  <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    addr  <= '0;
                end
            endcase
        end
    end

`ifdef LUT_CSUM_EN
    // Modulo-2**16 accumulate of one table entry (zero-extended).
    function automatic logic [15:0] csum_add(input logic [15:0]         acc,
                                             input logic [OUT_BITS-1:0] entry);
        return acc + 16'(entry);
    endfunction

    logic [15:0] csum_p1;
    assign cfg_csum = csum_p1;

    // ---- stage 0 -> 1: checksum of accepted entries ----------------------
    // Only accepted writes are summed, so the entry dropped by a coincident
    // cfg_start never contributes. The value holds after cfg_done because
    // no further writes occur outside LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_p1 <= '0;
        end else if (cfg_start) begin
            csum_p1 <= '0;
        end else if (wr_en) begin
            csum_p1 <= csum_add(csum_p1, cfg_data);
        end
    end
`endif

endmodule
